// File: rtl/ex_muldiv_unit_if.sv
// EX-stage multiply/divide request/result bundle shared by the pipeline and the unit.
interface ex_muldiv_unit_if #(
    parameter int unsigned S = 32
);
    logic         ex_start;
    logic [2:0]   ex_op;
    logic [S-1:0] ex_ReadRegister1;
    logic [S-1:0] ex_ReadRegister2;
    logic         flush;
    logic         md_stall;
    logic         md_done;
    logic [S-1:0] hi;
    logic [S-1:0] lo;

    // Pipeline side: issues operations and observes stall/results.
    modport master (
        output ex_start, ex_op, ex_ReadRegister1, ex_ReadRegister2, flush,
        input  md_stall, md_done, hi, lo
    );

    // Unit side.
    modport slave (
        input  ex_start, ex_op, ex_ReadRegister1, ex_ReadRegister2, flush,
        output md_stall, md_done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// One product/quotient bit per cycle; stalls the front of the pipeline while busy.
module ex_muldiv_unit #(
    parameter int unsigned S = 32
) (
    input  logic                clk,
    input  logic                reset,
    ex_muldiv_unit_if.slave     bus
);
    localparam int unsigned CW        = $clog2(S);
    localparam logic [CW-1:0] CNT_LAST = CW'(S - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  counter_q;
    logic [2*S-1:0] acc_q;       // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [S-1:0]   opnd_q;      // multiplicand or divisor magnitude
    logic [S-1:0]   rs_raw_q;    // unmodified rs, returned in HI on divide by zero
    logic [S-1:0]   hi_q, lo_q;
    logic           is_div_q, sign_q_q, sign_r_q, div_zero_q, md_done_q;

    logic           start_md_c, rs_neg_c, rt_neg_c, stall_c;
    logic [S-1:0]   rs_mag_c, rt_mag_c;
    logic [S:0]     mul_sum_c, div_shift_c, div_trial_c;
    logic [2*S-1:0] step_c, prod_c;
    logic [S-1:0]   quot_c, rem_c;

    assign start_md_c = bus.ex_start & ~bus.ex_op[2] & ~bus.flush;
    assign rs_neg_c   = ~bus.ex_op[0] & bus.ex_ReadRegister1[S-1];
    assign rt_neg_c   = ~bus.ex_op[0] & bus.ex_ReadRegister2[S-1];
    assign rs_mag_c   = rs_neg_c ? ({S{1'b0}} - bus.ex_ReadRegister1) : bus.ex_ReadRegister1;
    assign rt_mag_c   = rt_neg_c ? ({S{1'b0}} - bus.ex_ReadRegister2) : bus.ex_ReadRegister2;

    assign bus.md_stall = stall_c;
    assign bus.md_done  = md_done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    // One shift-add or restoring-divide step, plus sign-corrected final results.
    always_comb begin
        mul_sum_c   = {1'b0, acc_q[2*S-1:S]} + (acc_q[0] ? {1'b0, opnd_q} : {(S+1){1'b0}});
        div_shift_c = {acc_q[2*S-1:S], acc_q[S-1]};
        div_trial_c = div_shift_c - {1'b0, opnd_q};
        step_c      = {mul_sum_c, acc_q[S-1:1]};
        if (is_div_q) begin
            if (div_trial_c[S]) begin
                step_c = {div_shift_c[S-1:0], acc_q[S-2:0], 1'b0};
            end else begin
                step_c = {div_trial_c[S-1:0], acc_q[S-2:0], 1'b1};
            end
        end
        prod_c = sign_q_q ? ({(2*S){1'b0}} - step_c) : step_c;
        quot_c = sign_q_q ? ({S{1'b0}} - step_c[S-1:0]) : step_c[S-1:0];
        rem_c  = sign_r_q ? ({S{1'b0}} - step_c[2*S-1:S]) : step_c[2*S-1:S];
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and pipeline stall.
    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_md_c) begin
                    state_d = RUN;
                    stall_c = 1'b1;
                end
            end
            RUN: begin
                stall_c = 1'b1;
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (counter_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and HI/LO commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter_q  <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            rs_raw_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            div_zero_q <= 1'b0;
            md_done_q  <= 1'b0;
        end else begin
            md_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_md_c) begin
                        is_div_q   <= bus.ex_op[1];
                        sign_q_q   <= rs_neg_c ^ rt_neg_c;
                        sign_r_q   <= rs_neg_c;
                        div_zero_q <= (bus.ex_ReadRegister2 == '0);
                        rs_raw_q   <= bus.ex_ReadRegister1;
                        counter_q  <= CNT_LAST;
                        if (bus.ex_op[1]) begin
                            acc_q  <= {{S{1'b0}}, rs_mag_c};
                            opnd_q <= rt_mag_c;
                        end else begin
                            acc_q  <= {{S{1'b0}}, rt_mag_c};
                            opnd_q <= rs_mag_c;
                        end
                    end else if (bus.ex_start && bus.ex_op == 3'b100) begin
                        hi_q <= bus.ex_ReadRegister1;
                    end else if (bus.ex_start && bus.ex_op == 3'b101) begin
                        lo_q <= bus.ex_ReadRegister1;
                    end
                end
                RUN: begin
                    if (!bus.flush) begin
                        acc_q     <= step_c;
                        counter_q <= counter_q - CW'(1);
                        if (counter_q == '0) begin
                            md_done_q <= 1'b1;
                            if (!is_div_q) begin
                                hi_q <= prod_c[2*S-1:S];
                                lo_q <= prod_c[S-1:0];
                            end else if (div_zero_q) begin
                                hi_q <= rs_raw_q;
                                lo_q <= {S{1'b1}};
                            end else begin
                                hi_q <= rem_c;
                                lo_q <= quot_c;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: vector table plus hand sequences.
module tb_ex_muldiv_unit;
    localparam int unsigned S = 32;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];
    vec_t vecs[16];

    ex_muldiv_unit_if #(.S(S)) bus ();

    ex_muldiv_unit #(.S(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Scoreboard: every md_done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && bus.md_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got md_done=1 expected no pending op");
            end else begin
                e = sb.pop_front();
                check("sb_hi", bus.hi, e.hi);
                check("sb_lo", bus.lo, e.lo);
            end
        end
    end

    // Issue one mult/div; noisy keeps MTHI requests on the bus during RUN and DONE.
    task automatic run_vec(input vec_t v, input bit noisy);
        int   stalls;
        exp_t e;
        @(negedge clk);
        bus.ex_start         = 1'b1;
        bus.ex_op            = v.op;
        bus.ex_ReadRegister1 = v.rs;
        bus.ex_ReadRegister2 = v.rt;
        e.hi = v.ehi;
        e.lo = v.elo;
        sb.push_back(e);
        stalls = 0;
        #1;
        while (bus.md_stall === 1'b1 && stalls < 100) begin
            stalls++;
            @(negedge clk);
            if (noisy) begin
                bus.ex_start         = 1'b1;
                bus.ex_op            = 3'b100;
                bus.ex_ReadRegister1 = 32'hDEADBEEF;
            end else begin
                bus.ex_start = 1'b0;
            end
            #1;
        end
        check("stall_len", 32'(stalls), 32'(S + 1));
        check("done_pulse", {31'b0, bus.md_done}, 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);
        bus.ex_start = 1'b0;
        #1;
        check("done_low", {31'b0, bus.md_done}, 32'd0);
        check("hold_hi", bus.hi, v.ehi);
        check("hold_lo", bus.lo, v.elo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ph, pl;
        n_cmp = 0;
        n_err = 0;

        vecs[0]  = '{3'b000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[4]  = '{3'b010, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[5]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{3'b011, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[8]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{3'b011, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[10] = '{3'b000, 32'h00003039, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFCFC7};
        vecs[11] = '{3'b010, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};
        vecs[12] = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        vecs[13] = '{3'b001, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[14] = '{3'b001, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
        vecs[15] = '{3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};

        reset                = 1'b0;
        bus.ex_start         = 1'b0;
        bus.ex_op            = 3'b000;
        bus.ex_ReadRegister1 = '0;
        bus.ex_ReadRegister2 = '0;
        bus.flush            = 1'b0;
        #1;
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_stall", {31'b0, bus.md_stall}, 32'd0);
        check("rst_done", {31'b0, bus.md_done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Table-driven mult/div vectors.
        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], 1'b0);
        end

        // Start requests (MTHI) held during RUN and DONE must not disturb the result.
        run_vec('{3'b001, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0000001E}, 1'b1);

        // MTHI then MTLO: single cycle, no stall, no done.
        @(negedge clk);
        bus.ex_start         = 1'b1;
        bus.ex_op            = 3'b100;
        bus.ex_ReadRegister1 = 32'hA5A5A5A5;
        #1;
        check("mthi_stall", {31'b0, bus.md_stall}, 32'd0);
        @(negedge clk);
        bus.ex_start = 1'b0;
        #1;
        check("mthi_hi", bus.hi, 32'hA5A5A5A5);
        check("mthi_lo", bus.lo, 32'h0000001E);
        check("mthi_done", {31'b0, bus.md_done}, 32'd0);
        @(negedge clk);
        bus.ex_start         = 1'b1;
        bus.ex_op            = 3'b101;
        bus.ex_ReadRegister1 = 32'h5A5A5A5A;
        #1;
        check("mtlo_stall", {31'b0, bus.md_stall}, 32'd0);
        @(negedge clk);
        bus.ex_start = 1'b0;
        #1;
        check("mtlo_lo", bus.lo, 32'h5A5A5A5A);
        check("mtlo_hi", bus.hi, 32'hA5A5A5A5);
        check("mtlo_done", {31'b0, bus.md_done}, 32'd0);

        // Flush in RUN cycle 10: back to IDLE, HI/LO untouched, no done pulse.
        ph = bus.hi;
        pl = bus.lo;
        @(negedge clk);
        bus.ex_start         = 1'b1;
        bus.ex_op            = 3'b000;
        bus.ex_ReadRegister1 = 32'h00000005;
        bus.ex_ReadRegister2 = 32'h00000007;
        repeat (10) begin
            @(negedge clk);
            bus.ex_start = 1'b0;
        end
        bus.flush = 1'b1;
        #1;
        check("flush_run_stall", {31'b0, bus.md_stall}, 32'd1);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush_idle_stall", {31'b0, bus.md_stall}, 32'd0);
        check("flush_hi", bus.hi, ph);
        check("flush_lo", bus.lo, pl);
        repeat (40) @(negedge clk);
        #1;
        check("flush_quiet_stall", {31'b0, bus.md_stall}, 32'd0);
        check("flush_quiet_hi", bus.hi, ph);

        // Async reset in RUN cycle 5 clears everything without a clock edge.
        @(negedge clk);
        bus.ex_start         = 1'b1;
        bus.ex_op            = 3'b001;
        bus.ex_ReadRegister1 = 32'h00001234;
        bus.ex_ReadRegister2 = 32'h00005678;
        repeat (5) begin
            @(negedge clk);
            bus.ex_start = 1'b0;
        end
        #2;
        reset = 1'b0;
        #1;
        check("arst_hi", bus.hi, 32'h0);
        check("arst_lo", bus.lo, 32'h0);
        check("arst_stall", {31'b0, bus.md_stall}, 32'd0);
        check("arst_done", {31'b0, bus.md_done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Unit recovers cleanly after the aborted operation.
        run_vec('{3'b010, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2}, 1'b0);

        check("sb_final", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage.
- Consumes the operand values that the ID/EX pipeline register presents to EX: rs value and rt value.
- Executes MIPS MULT/MULTU/DIV/DIVU iteratively and writes the HI/LO registers.
- While busy, drives a stall back toward the ID/EX and earlier pipeline registers; also services MTHI/MTLO in a single cycle.

Parameters:
S, 32, data width of operands and of HI/LO; iteration count equals S.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
ex_start  in  1  operation request from EX, sampled on clk
ex_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored
ex_ReadRegister1  in  S  rs value (multiplicand/dividend; MTHI/MTLO source)
ex_ReadRegister2  in  S  rt value (multiplier/divisor)
flush  in  1  abort any in-flight operation
md_stall  out  1  pipeline must hold ID/EX and earlier
md_done  out  1  one-cycle pulse: HI/LO just updated by mult/div
hi  out  S  HI register
lo  out  S  LO register

Behaviour:
- Reset (reset=0, async): state=IDLE, hi=0, lo=0, md_done=0, md_stall=0, counter=0, internal operands=0.
- FSM states: IDLE, RUN, DONE.
- IDLE with ex_start=1, ex_op in 000-011 and flush=0:
  - Latch operand magnitudes: abs() only for signed ops.
  - Latch result signs:
    - Product/quotient sign = sign(rs) XOR sign(rt).
    - Remainder sign = sign(rs).
  - counter=S-1; go to RUN.
- IDLE with ex_start=1, op 100: hi<=rs at that edge; op 101: lo<=rs. No stall, no md_done, stays IDLE.
- RUN:
  - Multiply: shift-add, one bit per cycle.
  - Divide: restoring, one quotient bit per cycle.
  - Exactly S cycles in RUN; counter decrements each cycle.
  - On the edge leaving RUN (counter=0), write sign-corrected results and go to DONE:
    - Multiply: {hi,lo} = 2S-bit product.
    - Divide: lo = quotient, hi = remainder.
- DONE: md_done=1 for exactly this cycle; next edge -> IDLE. New starts in DONE are ignored.
- md_stall (combinational) = (state==RUN) | (state==IDLE & ex_start & ex_op in 000-011 & ~flush). Low in DONE.
- Total: stall high S+1 consecutive cycles; hi/lo valid in the cycle md_done=1.
- Divide by zero (rt=0, signed or unsigned): lo=all ones, hi=rs unmodified. No sign correction; same latency.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- flush=1 in RUN: next edge -> IDLE; hi/lo unchanged; no md_done.
- flush=1 in DONE: no effect, since the result is already committed.
- ex_start in RUN/DONE: ignored. MTHI/MTLO never modify hi/lo during RUN.
- Reset asserted mid-operation: immediate clear as above; the operation is lost.
- All arithmetic is internally 2S-bit for the product, with S+1-bit remainder compare. Results are truncated to S bits per register.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=0x00000003 -> md_stall high 33 consecutive cycles; md_done pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU rs=7, rt=2 -> lo=3, hi=1.
- DIV rs=0x12345678, rt=0 -> lo=0xFFFFFFFF, hi=0x12345678. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0xA5A5A5A5 -> hi=0xA5A5A5A5 after one edge, lo unchanged, md_stall and md_done stay 0. Then MTLO rs=0x5A5A5A5A -> lo updated.
- MULT, with flush in RUN cycle 10 -> IDLE next edge, hi/lo hold prior values, no md_done. Separately, reset=0 in RUN cycle 5 -> hi=lo=0, md_stall=0 immediately, without waiting for a clock edge.
